multicycle_control_fsm: RTL

Multi-cycle sequencing controller for the KGP-RISC core. It decodes the 6-bit opcode and 11-bit opcode extension into the datapath control set, and steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It handshakes with instruction and data memory, resolves conditional branches from the datapath flags, traps illegal encodings and bus timeouts, and counts retired instructions. It sits between the instruction register and the datapath muxes, ALU and register file.

---
 rtl/multicycle_control_fsm_if.sv | 47 ++++
 rtl/multicycle_control_fsm.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control/handshake bundle between the KGP-RISC sequencer and the IR, datapath and memories.
// The sequencer connects through the slave modport; its environment uses master.
interface multicycle_control_fsm_if #(
  parameter int OPC_W = 6,
  parameter int EXT_W = 11,
  parameter int CNT_W = 32
);
  logic [OPC_W-1:0] opcode;
  logic [EXT_W-1:0] opcode_ext;
  logic             zero;
  logic             carry;
  logic             sign;
  logic             overflow;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_load;
  logic             pc_write;
  logic             branch_taken;
  logic [3:0]       alu_control;
  logic             regWrite;
  logic             MemWrite;
  logic             MemRead;
  logic             ALU_src;
  logic             const_src;
  logic             reg_data;
  logic             reg_to_pc;
  logic             regWrite_select;
  logic             illegal;
  logic             bus_err;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;

  modport master (
    output opcode, opcode_ext, zero, carry, sign, overflow, imem_ready, dmem_ready,
    input  imem_req, ir_load, pc_write, branch_taken, alu_control, regWrite, MemWrite,
           MemRead, ALU_src, const_src, reg_data, reg_to_pc, regWrite_select,
           illegal, bus_err, state, instret
  );

  modport slave (
    input  opcode, opcode_ext, zero, carry, sign, overflow, imem_ready, dmem_ready,
    output imem_req, ir_load, pc_write, branch_taken, alu_control, regWrite, MemWrite,
           MemRead, ALU_src, const_src, reg_data, reg_to_pc, regWrite_select,
           illegal, bus_err, state, instret
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// KGP-RISC multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshakes,
// branch resolution, illegal/timeout traps and a retired-instruction counter.
module multicycle_control_fsm #(
  parameter int OPC_W   = 6,
  parameter int EXT_W   = 11,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input logic clk,
  input logic rst,
  multicycle_control_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  typedef struct packed {
    logic [3:0] alu;
    logic       alu_src;
    logic       const_src;
    logic       reg_data;
    logic       reg_to_pc;
    logic       rw_sel;
  } ctrl_t;

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [OPC_W-1:0] OP_ALU   = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_BR    = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_BRR   = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_BC_LO = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_BC_HI = OPC_W'(12);
  localparam logic [OPC_W-1:0] OP_CALL  = OPC_W'(13);
  localparam logic [OPC_W-1:0] OP_RET   = OPC_W'(14);
  localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(15);
  localparam logic [OPC_W-1:0] OP_COMPI = OPC_W'(16);

  state_e            state_q, state_d;
  ctrl_t             ctrl_q, ctrl_d, dec_s;
  logic              dec_ok_s;
  logic [OPC_W-1:0]  op_q, op_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  instret_q;
  logic              imem_req_s, ir_load_s, pc_write_s, taken_s;
  logic              reg_write_s, mem_read_s, mem_write_s;

  function automatic logic [3:0] alu_of_ext(input logic [3:0] ext);
    case (ext)
      4'd0:    alu_of_ext = 4'd0;
      4'd1:    alu_of_ext = 4'd1;
      4'd2:    alu_of_ext = 4'd2;
      4'd3:    alu_of_ext = 4'd3;
      4'd4:    alu_of_ext = 4'd4;
      4'd5:    alu_of_ext = 4'd5;
      4'd6:    alu_of_ext = 4'd4;
      4'd7:    alu_of_ext = 4'd5;
      4'd8:    alu_of_ext = 4'd6;
      4'd9:    alu_of_ext = 4'd6;
      default: alu_of_ext = 4'd0;
    endcase
  endfunction

  // Opcodes 5..12 test zero, carry, sign, overflow in pairs: true, then inverted.
  function automatic logic branch_cond(input logic [OPC_W-1:0] op, input logic z,
                                       input logic cy, input logic sg, input logic ov);
    case (op)
      OPC_W'(5):  branch_cond = z;
      OPC_W'(6):  branch_cond = ~z;
      OPC_W'(7):  branch_cond = cy;
      OPC_W'(8):  branch_cond = ~cy;
      OPC_W'(9):  branch_cond = sg;
      OPC_W'(10): branch_cond = ~sg;
      OPC_W'(11): branch_cond = ov;
      OPC_W'(12): branch_cond = ~ov;
      default:    branch_cond = 1'b0;
    endcase
  endfunction

  // Instruction decode into the datapath control set.
  always_comb begin
    dec_s    = '0;
    dec_ok_s = 1'b1;
    case (bus.opcode) inside
      OP_ALU: begin
        if (bus.opcode_ext <= EXT_W'(9)) begin
          dec_s.alu      = alu_of_ext(bus.opcode_ext[3:0]);
          dec_s.reg_data = 1'b1;
          if ((bus.opcode_ext == EXT_W'(4)) || (bus.opcode_ext == EXT_W'(5)) ||
              (bus.opcode_ext == EXT_W'(8))) begin
            dec_s.alu_src   = 1'b1;
            dec_s.const_src = 1'b1;
          end else begin
            dec_s.alu_src   = 1'b0;
            dec_s.const_src = 1'b0;
          end
        end else begin
          dec_ok_s = 1'b0;
        end
      end
      OP_LW, OP_SW: begin
        dec_s.alu     = 4'd9;
        dec_s.alu_src = 1'b1;
        dec_s.rw_sel  = 1'b1;
      end
      OP_BR, [OP_BC_LO:OP_BC_HI]: begin
        dec_s.alu     = 4'd8;
        dec_s.alu_src = 1'b1;
      end
      OP_BRR: dec_s.alu = 4'd7;
      OP_CALL: begin
        dec_s.alu_src   = 1'b1;
        dec_s.reg_to_pc = 1'b1;
      end
      OP_RET: begin
        dec_s.alu       = 4'd7;
        dec_s.reg_to_pc = 1'b1;
      end
      OP_ADDI, OP_COMPI: begin
        dec_s.alu      = (bus.opcode == OP_COMPI) ? 4'd1 : 4'd0;
        dec_s.alu_src  = 1'b1;
        dec_s.reg_data = 1'b1;
      end
      default: dec_ok_s = 1'b0;
    endcase
  end

  // Next-state and strobe logic; controls are cleared whenever FETCH or TRAP is entered.
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    op_d        = op_q;
    wait_d      = '0;
    illegal_d   = illegal_q;
    bus_err_d   = bus_err_q;
    imem_req_s  = 1'b0;
    ir_load_s   = 1'b0;
    pc_write_s  = 1'b0;
    taken_s     = 1'b0;
    reg_write_s = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_s = 1'b1;
        if (bus.imem_ready) begin
          ir_load_s = 1'b1;
          state_d   = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
          ctrl_d    = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        op_d = bus.opcode;
        if (dec_ok_s) begin
          ctrl_d  = dec_s;
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_EXEC: begin
        case (op_q) inside
          OP_LW, OP_SW: state_d = S_MEM;
          OP_BR, OP_BRR, OP_RET: begin
            pc_write_s = 1'b1;
            taken_s    = 1'b1;
            ctrl_d     = '0;
            state_d    = S_FETCH;
          end
          [OP_BC_LO:OP_BC_HI]: begin
            pc_write_s = 1'b1;
            taken_s    = branch_cond(op_q, bus.zero, bus.carry, bus.sign, bus.overflow);
            ctrl_d     = '0;
            state_d    = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_read_s  = (op_q == OP_LW);
        mem_write_s = (op_q != OP_LW);
        if (bus.dmem_ready) begin
          if (op_q == OP_LW) begin
            state_d = S_WB;
          end else begin
            pc_write_s = 1'b1;
            ctrl_d     = '0;
            state_d    = S_FETCH;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
          ctrl_d    = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        reg_write_s = 1'b1;
        pc_write_s  = 1'b1;
        taken_s     = (op_q == OP_CALL);
        ctrl_d      = '0;
        state_d     = S_FETCH;
      end
      S_TRAP: ctrl_d = '0;
      default: begin
        ctrl_d  = '0;
        state_d = S_TRAP;
      end
    endcase
  end

  // State, latched controls, wait counter, sticky trap causes and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ctrl_q    <= '0;
      op_q      <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      instret_q <= instret_q + CNT_W'(pc_write_s);
    end
  end

  // Strobes are held off while reset is asserted so nothing escapes an aborted instruction.
  assign bus.imem_req        = imem_req_s  & ~rst;
  assign bus.ir_load         = ir_load_s   & ~rst;
  assign bus.pc_write        = pc_write_s  & ~rst;
  assign bus.branch_taken    = taken_s     & ~rst;
  assign bus.regWrite        = reg_write_s & ~rst;
  assign bus.MemRead         = mem_read_s  & ~rst;
  assign bus.MemWrite        = mem_write_s & ~rst;
  assign bus.alu_control     = ctrl_q.alu;
  assign bus.ALU_src         = ctrl_q.alu_src;
  assign bus.const_src       = ctrl_q.const_src;
  assign bus.reg_data        = ctrl_q.reg_data;
  assign bus.reg_to_pc       = ctrl_q.reg_to_pc;
  assign bus.regWrite_select = ctrl_q.rw_sel;
  assign bus.illegal         = illegal_q;
  assign bus.bus_err         = bus_err_q;
  assign bus.state           = state_q;
  assign bus.instret         = instret_q;

endmodule
